// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//
// Multi-cycle RV32I control FSM. It walks each instruction through
// FETCH -> DECODE -> EXECUTE (-> memory states) and emits the control
// strobes for the memory port, register file and PC. A halt is entered on
// SYSTEM (clean stop), on an unrecognised opcode, or when memory fails to
// acknowledge within TIMEOUT_CYCLES consecutive wait cycles. The latter two
// also raise fault.
//
// Parameters
//   TIMEOUT_CYCLES          consecutive wait cycles without mem_ack_i in one
//                           memory state before the sequencer faults (>= 1)
//
// Ports
//   clk                     rising-edge clock
//   rst_n                   asynchronous active-low reset
//   opcode_i[6:0]           RV32I opcode, sampled only in DECODE
//   mem_ack_i               memory finished the requested access this cycle
//   mem_request_o           memory access requested this cycle
//   memory_mode_o[1:0]      0=LOAD 1=STORE_PRELOAD 2=STORE
//   fetch_enable_o          current access is an instruction fetch
//   rd_source_o[1:0]        0=MEMORY 1=ALU 2=IMMEDIATE_FORMER 3=BRANCH_ALU
//   immediate_former_mode_o 0=LUI 1=AUIPC
//   branch_alu_mode_o[1:0]  0=JAL 1=JALR 2=BRANCH 3=INCREMENT
//   rd_write_enable_o       one-cycle register-file write strobe
//   pc_write_enable_o       one-cycle PC update strobe (retirement)
//   halted_o                sequencer is in HALT
//   fault_o                 HALT was caused by illegal opcode or timeout
//   instret_o[31:0]         retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module control_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode_i,
    input  logic        mem_ack_i,
    output logic        mem_request_o,
    output logic [1:0]  memory_mode_o,
    output logic        fetch_enable_o,
    output logic [1:0]  rd_source_o,
    output logic        immediate_former_mode_o,
    output logic [1:0]  branch_alu_mode_o,
    output logic        rd_write_enable_o,
    output logic        pc_write_enable_o,
    output logic        halted_o,
    output logic        fault_o,
    output logic [31:0] instret_o
);

    // RV32I major opcodes recognised in EXECUTE.
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // The counter never holds more than TIMEOUT_CYCLES-1: the wait cycle
    // that would push it to TIMEOUT_CYCLES leaves the state instead.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM_LOAD,
        S_MEM_PRELOAD,
        S_MEM_STORE,
        S_HALT
    } state_e;

    typedef enum logic [1:0] {
        MODE_LOAD          = 2'd0,
        MODE_STORE_PRELOAD = 2'd1,
        MODE_STORE         = 2'd2
    } mem_mode_e;

    typedef enum logic [1:0] {
        SRC_MEMORY     = 2'd0,
        SRC_ALU        = 2'd1,
        SRC_IMM_FORMER = 2'd2,
        SRC_BRANCH_ALU = 2'd3
    } rd_src_e;

    typedef enum logic [1:0] {
        BR_JAL       = 2'd0,
        BR_JALR      = 2'd1,
        BR_BRANCH    = 2'd2,
        BR_INCREMENT = 2'd3
    } br_mode_e;

    state_e           state_q,   state_d;
    logic [6:0]       opcode_q,  opcode_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic [31:0]      instret_q, instret_d;
    logic             fault_q,   fault_d;

    mem_mode_e mem_mode;
    rd_src_e   rd_src;
    br_mode_e  br_mode;
    logic      timeout_hit;
    logic      wait_state;

    assign timeout_hit = (count_q == CNT_LAST);
    assign wait_state  = (state_q == S_FETCH)       || (state_q == S_MEM_LOAD) ||
                         (state_q == S_MEM_PRELOAD) || (state_q == S_MEM_STORE);

    // NOTE: every signal written below gets its default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d                 = state_q;
        fault_d                 = fault_q;
        mem_request_o           = 1'b0;
        mem_mode                = MODE_LOAD;
        fetch_enable_o          = 1'b0;
        rd_src                  = SRC_ALU;
        immediate_former_mode_o = 1'b0;
        br_mode                 = BR_INCREMENT;
        rd_write_enable_o       = 1'b0;
        pc_write_enable_o       = 1'b0;
        halted_o                = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                mem_request_o  = 1'b1;
                fetch_enable_o = 1'b1;
                if (mem_ack_i) begin
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end
            end

            S_DECODE: state_d = S_EXECUTE;

            S_EXECUTE: begin
                state_d = S_FETCH;
                case (opcode_q)
                    OPC_OP, OPC_OP_IMM: begin
                        rd_write_enable_o = 1'b1;
                        pc_write_enable_o = 1'b1;
                    end
                    OPC_LUI, OPC_AUIPC: begin
                        rd_src                  = SRC_IMM_FORMER;
                        immediate_former_mode_o = (opcode_q == OPC_AUIPC);
                        rd_write_enable_o       = 1'b1;
                        pc_write_enable_o       = 1'b1;
                    end
                    OPC_JAL, OPC_JALR: begin
                        rd_src            = SRC_BRANCH_ALU;
                        br_mode           = (opcode_q == OPC_JALR) ? BR_JALR : BR_JAL;
                        rd_write_enable_o = 1'b1;
                        pc_write_enable_o = 1'b1;
                    end
                    OPC_BRANCH: begin
                        br_mode           = BR_BRANCH;
                        pc_write_enable_o = 1'b1;
                    end
                    OPC_MISC_MEM: pc_write_enable_o = 1'b1;  // fences retire as NOPs
                    OPC_LOAD:     state_d = S_MEM_LOAD;
                    OPC_STORE:    state_d = S_MEM_PRELOAD;
                    OPC_SYSTEM:   state_d = S_HALT;
                    default: begin
                        state_d = S_HALT;
                        fault_d = 1'b1;
                    end
                endcase
            end

            S_MEM_LOAD: begin
                mem_request_o = 1'b1;
                if (mem_ack_i) begin
                    rd_src            = SRC_MEMORY;
                    rd_write_enable_o = 1'b1;
                    pc_write_enable_o = 1'b1;
                    state_d           = S_FETCH;
                end else if (timeout_hit) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end
            end

            S_MEM_PRELOAD: begin
                mem_request_o = 1'b1;
                mem_mode      = MODE_STORE_PRELOAD;
                if (mem_ack_i) begin
                    state_d = S_MEM_STORE;
                end else if (timeout_hit) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end
            end

            S_MEM_STORE: begin
                mem_request_o = 1'b1;
                mem_mode      = MODE_STORE;
                if (mem_ack_i) begin
                    pc_write_enable_o = 1'b1;
                    state_d           = S_FETCH;
                end else if (timeout_hit) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end
            end

            S_HALT: halted_o = 1'b1;  // sticky until reset

            default: state_d = S_HALT;
        endcase

        // The wait counter measures time spent in one state only.
        if (state_d != state_q) begin
            count_d = '0;
        end else if (wait_state && !mem_ack_i) begin
            count_d = count_q + 1'b1;
        end else begin
            count_d = count_q;
        end

        opcode_d  = (state_q == S_DECODE) ? opcode_i : opcode_q;
        instret_d = instret_q + {31'd0, pc_write_enable_o};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            opcode_q  <= '0;
            count_q   <= '0;
            instret_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            count_q   <= count_d;
            instret_q <= instret_d;
            fault_q   <= fault_d;
        end
    end

    assign memory_mode_o     = mem_mode;
    assign rd_source_o       = rd_src;
    assign branch_alu_mode_o = br_mode;
    assign fault_o           = fault_q;
    assign instret_o         = instret_q;

endmodule
